// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
//
// Sequencer that turns queued ALU operation requests into per-cycle datapath
// control lines. Requests are buffered in a 4-entry FIFO. Each one is replayed
// for op_cnt+1 consecutive cycles with constant control lines. Operations
// chain without a bubble when the FIFO holds the next request.
//
// Ports
//   CLK        clock; all state changes on the rising edge
//   Clr        asynchronous active-low reset
//   op_valid   upstream offers {op_code, op_cnt, op_lshl} this cycle
//   op_ready   FIFO not full (combinational from occupancy only)
//   op_code    operation select (3 bits)
//   op_cnt     repeat count; operation runs op_cnt+1 cycles
//   op_lshl    serial bit shifted in for SHL
//   V0         operand select: 1 = A, 0 = T (accumulator)
//   V1         operand select: 1 = B, 0 = C
//   M          0 = add, 1 = subtract
//   s0         0 = load arithmetic result, 1 = shift left
//   LSHL       shift-in bit (0 except for SHL)
//   exec_en    control lines valid; accumulator updates on this edge
//   done       final exec cycle of the current operation
//   busy       FSM in EXEC or FIFO non-empty
//   fifo_cnt   FIFO occupancy, 0..4
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing executing; control lines held at zero
// ST_EXEC | replaying the loaded operation; rem counts cycles left
// -----------------------------------------------------------------------------
module alu_ctrl_seq (
   input  logic       CLK,
   input  logic       Clr,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic [2:0] op_code,
   input  logic [3:0] op_cnt,
   input  logic       op_lshl,
   output logic       V0,
   output logic       V1,
   output logic       M,
   output logic       s0,
   output logic       LSHL,
   output logic       exec_en,
   output logic       done,
   output logic       busy,
   output logic [2:0] fifo_cnt
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] cnt_nxt;
   logic       push;
   logic       pop;
   logic       fifo_empty;

   logic [7:0] head;
   logic [2:0] head_code;
   logic [3:0] head_cnt;
   logic       head_lshl;

   // ctrl packs {V0, V1, M, s0, LSHL}
   logic [4:0] ctrl;
   logic [4:0] ctrl_nxt;
   logic [3:0] rem;
   logic [3:0] rem_nxt;
   logic       exec_nxt;
   logic       done_nxt;
   logic       busy_nxt;

   function automatic logic [4:0] decode(input logic [2:0] code, input logic lshl);
      logic [4:0] d;
      case (code)
         3'b000:  d = 5'b11000;   // A+B
         3'b001:  d = 5'b11100;   // A-B
         3'b010:  d = 5'b10000;   // A+C
         3'b011:  d = 5'b10100;   // A-C
         3'b100:  d = 5'b01000;   // T+B
         3'b101:  d = 5'b01100;   // T-B
         3'b110:  d = 5'b00000;   // T+C
         default: d = {4'b0001, lshl};  // SHL
      endcase
      return d;
   endfunction

   // Full blocks acceptance even when a pop happens the same cycle, so the
   // ready path never depends on the FSM.
   assign op_ready   = (fifo_cnt != 3'd4);
   assign push       = op_valid && op_ready;
   assign fifo_empty = (fifo_cnt == 3'd0);

   assign head = fifo_mem[rd_ptr];
   assign {head_code, head_cnt, head_lshl} = head;

   assign {V0, V1, M, s0, LSHL} = ctrl;

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      ctrl_nxt  = ctrl;
      exec_nxt  = 1'b0;
      done_nxt  = 1'b0;
      pop       = 1'b0;

      case (state)
         ST_IDLE: begin
            ctrl_nxt = 5'b00000;
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_EXEC;
               rem_nxt   = head_cnt;
               ctrl_nxt  = decode(head_code, head_lshl);
               exec_nxt  = 1'b1;
               done_nxt  = (head_cnt == 4'd0);
            end
         end

         ST_EXEC: begin
            if (rem != 4'd0) begin
               rem_nxt  = rem - 4'd1;
               exec_nxt = 1'b1;
               done_nxt = (rem == 4'd1);
            end else if (!fifo_empty) begin
               // Chain straight into the next request: no idle cycle.
               pop       = 1'b1;
               rem_nxt   = head_cnt;
               ctrl_nxt  = decode(head_code, head_lshl);
               exec_nxt  = 1'b1;
               done_nxt  = (head_cnt == 4'd0);
            end else begin
               state_nxt = ST_IDLE;
               ctrl_nxt  = 5'b00000;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            ctrl_nxt  = 5'b00000;
         end
      endcase
   end

   always_comb begin
      cnt_nxt = fifo_cnt;
      if (push && !pop) begin
         cnt_nxt = fifo_cnt + 3'd1;
      end else if (!push && pop) begin
         cnt_nxt = fifo_cnt - 3'd1;
      end
      busy_nxt = (state_nxt == ST_EXEC) || (cnt_nxt != 3'd0);
   end

   always_ff @(posedge CLK or negedge Clr) begin
      if (!Clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge Clr) begin
      if (!Clr) begin
         for (int i = 0; i < 4; i++) begin
            fifo_mem[i] <= 8'd0;
         end
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
         rem      <= 4'd0;
         ctrl     <= 5'b00000;
         exec_en  <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {op_code, op_cnt, op_lshl};
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         fifo_cnt <= cnt_nxt;
         rem      <= rem_nxt;
         ctrl     <= ctrl_nxt;
         exec_en  <= exec_nxt;
         done     <= done_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_seq
//
// Directed bench for alu_ctrl_seq. Inputs are driven and outputs sampled 1 ns
// after each rising edge. A small accumulator model (A=1, B=4, C=2) is
// steered by the DUT control lines for the datapath scenario.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_seq;

   logic       CLK;
   logic       Clr;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] op_code;
   logic [3:0] op_cnt;
   logic       op_lshl;
   logic       V0, V1, M, s0, LSHL;
   logic       exec_en, done, busy;
   logic [2:0] fifo_cnt;

   int compared   = 0;
   int mismatched = 0;

   alu_ctrl_seq dut (
      .CLK      (CLK),
      .Clr      (Clr),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .op_cnt   (op_cnt),
      .op_lshl  (op_lshl),
      .V0       (V0),
      .V1       (V1),
      .M        (M),
      .s0       (s0),
      .LSHL     (LSHL),
      .exec_en  (exec_en),
      .done     (done),
      .busy     (busy),
      .fifo_cnt (fifo_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Accumulator datapath model driven by the control lines.
   localparam logic [7:0] OPA = 8'd1;
   localparam logic [7:0] OPB = 8'd4;
   localparam logic [7:0] OPC = 8'd2;
   logic [7:0] acc;
   logic [7:0] acc_nxt;
   logic [7:0] acc_log [$];
   logic [7:0] src_a;
   logic [7:0] src_b;

   always_comb begin
      src_a = V0 ? OPA : acc;
      src_b = V1 ? OPB : OPC;
      if (s0) acc_nxt = {acc[6:0], LSHL};
      else if (M) acc_nxt = src_a - src_b;
      else acc_nxt = src_a + src_b;
   end

   always @(posedge CLK or negedge Clr) begin
      if (!Clr) acc <= 8'd0;
      else if (exec_en) acc <= acc_nxt;
   end

   always @(posedge CLK) begin
      if (Clr && exec_en) acc_log.push_back(acc_nxt);
   end

   wire [4:0] ctrl = {V0, V1, M, s0, LSHL};

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic offer(input logic [2:0] code, input logic [3:0] cnt, input logic lshl);
      op_valid = 1'b1;
      op_code  = code;
      op_cnt   = cnt;
      op_lshl  = lshl;
   endtask

   task automatic test_reset;
      Clr = 1'b0;
      offer(3'b000, 4'd0, 1'b0);
      tick; tick; tick;
      compared++; if (fifo_cnt !== 3'd0) begin mismatched++; $display("FAIL reset_fifo_cnt: got %0d want 0", fifo_cnt); end
      compared++; if (op_ready !== 1'b1) begin mismatched++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
      compared++; if (ctrl !== 5'b00000) begin mismatched++; $display("FAIL reset_ctrl: got %b want 00000", ctrl); end
      compared++; if ({exec_en, done, busy} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {exec_en, done, busy}); end
      op_valid = 1'b0;
      Clr = 1'b1;
      tick; tick;
      compared++; if ({exec_en, fifo_cnt} !== 4'b0000) begin mismatched++; $display("FAIL reset_release_idle: got exec_en=%b fifo_cnt=%0d want 0/0", exec_en, fifo_cnt); end
   endtask

   task automatic test_single;
      offer(3'b000, 4'd0, 1'b0);
      tick;
      op_valid = 1'b0;
      compared++; if ({exec_en, busy, fifo_cnt} !== 5'b01001) begin mismatched++; $display("FAIL single_pushed: got exec_en=%b busy=%b cnt=%0d want 0/1/1", exec_en, busy, fifo_cnt); end
      tick;
      compared++; if (ctrl !== 5'b11000) begin mismatched++; $display("FAIL single_ctrl: got %b want 11000", ctrl); end
      compared++; if ({exec_en, done, busy} !== 3'b111) begin mismatched++; $display("FAIL single_exec: got %b want 111", {exec_en, done, busy}); end
      compared++; if (fifo_cnt !== 3'd0) begin mismatched++; $display("FAIL single_fifo_cnt: got %0d want 0", fifo_cnt); end
      tick;
      compared++; if ({exec_en, done, busy} !== 3'b000) begin mismatched++; $display("FAIL single_after: got %b want 000", {exec_en, done, busy}); end
      compared++; if (ctrl !== 5'b00000) begin mismatched++; $display("FAIL single_idle_ctrl: got %b want 00000", ctrl); end
   endtask

   task automatic test_repeat;
      offer(3'b101, 4'd3, 1'b0);
      tick;
      op_valid = 1'b0;
      tick;
      for (int i = 0; i < 4; i++) begin
         compared++; if ({exec_en, ctrl} !== 6'b101100) begin mismatched++; $display("FAIL repeat_ctrl[%0d]: got exec_en=%b ctrl=%b want 1/01100", i, exec_en, ctrl); end
         compared++; if (done !== (i == 3)) begin mismatched++; $display("FAIL repeat_done[%0d]: got %b want %b", i, done, (i == 3)); end
         tick;
      end
      compared++; if ({exec_en, busy} !== 2'b00) begin mismatched++; $display("FAIL repeat_end: got exec_en=%b busy=%b want 0/0", exec_en, busy); end
   endtask

   task automatic test_back_to_back;
      // 010 with op_lshl=1 must still drive LSHL=0.
      logic [4:0] exp_ctrl [6] = '{5'b10000, 5'b10000, 5'b00011, 5'b00011, 5'b00011, 5'b00000};
      logic       exp_done [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      offer(3'b010, 4'd1, 1'b1);
      tick;
      for (int c = 0; c < 6; c++) begin
         if (c == 0) offer(3'b111, 4'd2, 1'b1);
         else if (c == 1) offer(3'b110, 4'd0, 1'b0);
         else op_valid = 1'b0;
         tick;
         compared++; if ({exec_en, ctrl} !== {1'b1, exp_ctrl[c]}) begin mismatched++; $display("FAIL b2b_ctrl[%0d]: got exec_en=%b ctrl=%b want 1/%b", c + 1, exec_en, ctrl, exp_ctrl[c]); end
         compared++; if (done !== exp_done[c]) begin mismatched++; $display("FAIL b2b_done[%0d]: got %b want %b", c + 1, done, exp_done[c]); end
      end
      tick;
      compared++; if ({exec_en, busy} !== 2'b00) begin mismatched++; $display("FAIL b2b_end: got exec_en=%b busy=%b want 0/0", exec_en, busy); end
   endtask

   task automatic test_full;
      logic [4:0] exp_ctrl [5] = '{5'b11100, 5'b10000, 5'b10100, 5'b01000, 5'b01100};
      int n;
      offer(3'b000, 4'd15, 1'b0);
      tick;
      offer(3'b001, 4'd0, 1'b0); tick;
      offer(3'b010, 4'd0, 1'b0); tick;
      offer(3'b011, 4'd0, 1'b0); tick;
      offer(3'b100, 4'd0, 1'b0); tick;
      offer(3'b101, 4'd0, 1'b0);
      compared++; if ({op_ready, fifo_cnt} !== 4'b0100) begin mismatched++; $display("FAIL full_reached: got ready=%b cnt=%0d want 0/4", op_ready, fifo_cnt); end
      n = 0;
      while (fifo_cnt == 3'd4 && n < 40) begin
         tick;
         n++;
      end
      compared++; if (n !== 13) begin mismatched++; $display("FAIL full_hold_cycles: got %0d want 13", n); end
      compared++; if ({op_ready, fifo_cnt} !== 4'b1011) begin mismatched++; $display("FAIL full_ready_back: got ready=%b cnt=%0d want 1/3", op_ready, fifo_cnt); end
      compared++; if ({exec_en, done, ctrl} !== {2'b11, exp_ctrl[0]}) begin mismatched++; $display("FAIL full_order[0]: got %b%b/%b want 11/%b", exec_en, done, ctrl, exp_ctrl[0]); end
      tick;
      op_valid = 1'b0;
      compared++; if (fifo_cnt !== 3'd3) begin mismatched++; $display("FAIL full_push_pop: got %0d want 3", fifo_cnt); end
      for (int i = 1; i < 5; i++) begin
         compared++; if ({exec_en, done, ctrl} !== {2'b11, exp_ctrl[i]}) begin mismatched++; $display("FAIL full_order[%0d]: got %b%b/%b want 11/%b", i, exec_en, done, ctrl, exp_ctrl[i]); end
         tick;
      end
      compared++; if ({exec_en, busy, fifo_cnt} !== 5'b00000) begin mismatched++; $display("FAIL full_end: got exec_en=%b busy=%b cnt=%0d want 0/0/0", exec_en, busy, fifo_cnt); end
   endtask

   task automatic test_reset_mid;
      int bad;
      offer(3'b011, 4'd7, 1'b0);
      tick;
      offer(3'b000, 4'd0, 1'b0); tick;
      offer(3'b001, 4'd0, 1'b0); tick;
      compared++; if ({exec_en, fifo_cnt} !== 4'b1010) begin mismatched++; $display("FAIL rstmid_pre: got exec_en=%b cnt=%0d want 1/2", exec_en, fifo_cnt); end
      Clr = 1'b0;
      #1;
      compared++; if ({ctrl, exec_en, done, busy} !== 8'd0) begin mismatched++; $display("FAIL rstmid_outputs: got ctrl=%b flags=%b want 0", ctrl, {exec_en, done, busy}); end
      compared++; if ({op_ready, fifo_cnt} !== 4'b1000) begin mismatched++; $display("FAIL rstmid_fifo: got ready=%b cnt=%0d want 1/0", op_ready, fifo_cnt); end
      tick; tick;
      compared++; if (fifo_cnt !== 3'd0) begin mismatched++; $display("FAIL rstmid_push_ignored: got %0d want 0", fifo_cnt); end
      op_valid = 1'b0;
      Clr = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (exec_en !== 1'b0 || fifo_cnt !== 3'd0) bad++;
      end
      compared++; if (bad !== 0) begin mismatched++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
   endtask

   task automatic test_datapath;
      // Every opcode once, cnt=0 each; A=1, B=4, C=2, SHL shifts in 0.
      logic [2:0] codes [8] = '{3'b000, 3'b101, 3'b100, 3'b010, 3'b011, 3'b001, 3'b110, 3'b111};
      logic [7:0] exp   [8] = '{8'd5, 8'd1, 8'd5, 8'd3, 8'd255, 8'd253, 8'd255, 8'd254};
      int n;
      acc_log.delete();
      for (int i = 0; i < 8; i++) begin
         offer(codes[i], 4'd0, 1'b0);
         tick;
      end
      op_valid = 1'b0;
      n = 0;
      while (busy && n < 30) begin
         tick;
         n++;
      end
      tick;
      compared++; if (acc_log.size() !== 8) begin mismatched++; $display("FAIL dp_count: got %0d want 8", acc_log.size()); end
      if (acc_log.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            compared++; if (acc_log[i] !== exp[i]) begin mismatched++; $display("FAIL dp_acc[%0d]: got %0d want %0d", i, acc_log[i], exp[i]); end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Clr      = 1'b0;
      op_valid = 1'b0;
      op_code  = 3'd0;
      op_cnt   = 4'd0;
      op_lshl  = 1'b0;
      test_reset;
      test_single;
      test_repeat;
      test_back_to_back;
      test_full;
      test_reset_mid;
      test_datapath;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
